serial_sub_8b: RTL and testbench

Bit-serial ripple-borrow subtractor. Computes diff = a - b - bin, one bit per clock, LSB first, using a single 1-bit full-subtractor cell. This is the inverse-arithmetic companion to the registered ripple-carry adder datapath. It serves area-constrained ALU paths where WIDTH-cycle latency is acceptable. Uses a start/busy/done handshake to the sequencing logic.

---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/full_sub_1b.sv | 16 +
 rtl/serial_sub_8b.sv | 122 ++++++++++++
 tb/tb_serial_sub_8b.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and sizing helpers for the bit-serial subtractor
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bit-counter width; a 1-bit floor keeps the smallest legal WIDTH usable.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_sub_1b.sv
// rtl/full_sub_1b.sv - combinational 1-bit full subtractor cell
module full_sub_1b (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out of a - b - bin.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_sub_8b.sv
// rtl/serial_sub_8b.sv - bit-serial ripple-borrow subtractor, LSB first; SUB_OVF_EN adds signed overflow
module serial_sub_8b
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic [WIDTH-2:0] d_sh;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             br_next;
  logic             last;
  logic [WIDTH-1:0] d_cat;
`ifdef SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  full_sub_1b u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (d),
    .bout (br_next)
  );

  // d_sh holds the WIDTH-1 finished low bits; the bit being computed completes the word.
  assign d_cat = {d, d_sh};
  assign last  = (state == RUN) && (cnt == CNT_LAST);
  assign busy  = (state == RUN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: accept only from IDLE, leave RUN after the top bit.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == CNT_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, one bit per cycle through the cell, result publish on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      br    <= 1'b0;
      d_sh  <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          br    <= bin;
          cnt   <= '0;
`ifdef SUB_OVF_EN
          a_msb <= a[WIDTH-1];
          b_msb <= b[WIDTH-1];
`endif
        end
      end else begin
        a_sh <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh <= {1'b0, b_sh[WIDTH-1:1]};
        br   <= br_next;
        d_sh <= d_cat[WIDTH-1:1];
        if (last) begin
          diff <= d_cat;
          bout <= br_next;
          done <= 1'b1;
`ifdef SUB_OVF_EN
          ovf  <= (a_msb != b_msb) && (d != a_msb);
`endif
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_8b.sv
// tb/tb_serial_sub_8b.sv - scoreboard bench for serial_sub_8b
module tb_serial_sub_8b;

  localparam int W = 8;

  typedef struct packed {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
`ifdef SUB_OVF_EN
  logic       ovf;
`endif

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  serial_sub_8b #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] d, input logic bo, input logic ov);
    exp_t e;
    e.diff = d;
    e.bout = bo;
    e.ovf  = ov;
    return e;
  endfunction

  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
    logic [8:0] r;
    r = {1'b0, ma} - {1'b0, mb} - {8'd0, mbin};
    return mk(r[7:0], r[8], (ma[7] != mb[7]) && (r[7] != ma[7]));
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                          input bit push, input exp_t e);
    a = ta;
    b = tb_v;
    bin = tbin;
    start = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    bin = 1'($urandom);
  endtask

  task automatic finish_op(input string name, input bit chain, input logic [7:0] ca,
                           input logic [7:0] cb, input logic cbin, input exp_t ce);
    int   cycles;
    int   busy_cnt;
    exp_t e;
    cycles = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cycles < 30) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (busy) busy_cnt++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, cycles);
    end else begin
      checks++;
      if (cycles != W) begin
        failures++;
        $display("FAIL %s_latency: got %0d cycles, required %0d", name, cycles, W);
      end
      checks++;
      if (busy_cnt != W) begin
        failures++;
        $display("FAIL %s_busy_len: got %0d cycles, required %0d", name, busy_cnt, W);
      end
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL %s_scoreboard: got done with empty queue, required an entry", name);
      end else begin
        e = sb.pop_front();
        if (diff !== e.diff) begin
          failures++;
          $display("FAIL %s_diff: got %h, required %h", name, diff, e.diff);
        end
        checks++;
        if (bout !== e.bout) begin
          failures++;
          $display("FAIL %s_bout: got %b, required %b", name, bout, e.bout);
        end
`ifdef SUB_OVF_EN
        checks++;
        if (ovf !== e.ovf) begin
          failures++;
          $display("FAIL %s_ovf: got %b, required %b", name, ovf, e.ovf);
        end
`endif
      end
    end
    if (chain) begin
      a = ca;
      b = cb;
      bin = cbin;
      start = 1'b1;
      sb.push_back(ce);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_pulse: got %b next cycle, required 0", name, done);
    end
    if (chain) begin
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_chain_accept: busy got %b, required 1", name, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    bin = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, diff, bout} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b, required all 0",
               busy, done, diff, bout);
    end
`ifdef SUB_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf: got %b, required 0", ovf);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy got %b, required 0", busy);
    end
  endtask

  task automatic test_basic();
    start_op(8'h5A, 8'h3C, 1'b0, 1'b1, mk(8'h1E, 1'b0, 1'b0));
    finish_op("basic_5a_3c", 1'b0, 8'h00, 8'h00, 1'b0, mk(8'h00, 1'b0, 1'b0));
    start_op(8'h00, 8'h01, 1'b0, 1'b1, mk(8'hFF, 1'b1, 1'b0));
    finish_op("basic_00_01", 1'b0, 8'h00, 8'h00, 1'b0, mk(8'h00, 1'b0, 1'b0));
  endtask

  task automatic test_back_to_back();
    start_op(8'h80, 8'h80, 1'b1, 1'b1, mk(8'hFF, 1'b1, 1'b0));
    finish_op("b2b_first", 1'b1, 8'h10, 8'h01, 1'b0, mk(8'h0F, 1'b0, 1'b0));
    finish_op("b2b_second", 1'b0, 8'h00, 8'h00, 1'b0, mk(8'h00, 1'b0, 1'b0));
  endtask

  task automatic test_ignore_busy();
    int   dcount;
    int   dcycle;
    exp_t e;
    dcount = 0;
    dcycle = -1;
    start_op(8'hFF, 8'h0F, 1'b0, 1'b1, mk(8'hF0, 1'b0, 1'b0));
    for (int c = 1; c <= 20; c++) begin
      if (c == 4) begin
        a = 8'h00;
        b = 8'hFF;
        bin = 1'b0;
        start = 1'b1;
      end
      if (c == 5) start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        dcount++;
        dcycle = c;
        e = sb.pop_front();
        checks++;
        if ({diff, bout} !== {e.diff, e.bout}) begin
          failures++;
          $display("FAIL ignore_result: got diff=%h bout=%b, required diff=%h bout=%b",
                   diff, bout, e.diff, e.bout);
        end
      end
    end
    checks++;
    if (dcount != 1) begin
      failures++;
      $display("FAIL ignore_done_count: got %0d, required 1", dcount);
    end
    checks++;
    if (dcycle != W) begin
      failures++;
      $display("FAIL ignore_latency: got %0d, required %0d", dcycle, W);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_idle: busy got %b, required 0", busy);
    end
  endtask

  task automatic test_rst_mid();
    int dcount;
    dcount = 0;
    start_op(8'h33, 8'h11, 1'b0, 1'b0, mk(8'h22, 1'b0, 1'b0));
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, diff, bout} !== 11'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got busy=%b done=%b diff=%h bout=%b, required all 0",
               busy, done, diff, bout);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    checks++;
    if (dcount != 0) begin
      failures++;
      $display("FAIL rst_mid_no_done: got %0d done pulses, required 0", dcount);
    end
    start_op(8'h33, 8'h11, 1'b0, 1'b1, mk(8'h22, 1'b0, 1'b0));
    finish_op("rst_mid_rerun", 1'b0, 8'h00, 8'h00, 1'b0, mk(8'h00, 1'b0, 1'b0));
  endtask

  task automatic test_random();
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rbin;
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rbin = 1'($urandom);
      start_op(ra, rb, rbin, 1'b1, model(ra, rb, rbin));
      finish_op("random", 1'b0, 8'h00, 8'h00, 1'b0, mk(8'h00, 1'b0, 1'b0));
    end
  endtask

`ifdef SUB_OVF_EN
  task automatic test_ovf();
    start_op(8'h80, 8'h01, 1'b0, 1'b1, mk(8'h7F, 1'b0, 1'b1));
    finish_op("ovf_80_01", 1'b0, 8'h00, 8'h00, 1'b0, mk(8'h00, 1'b0, 1'b0));
    start_op(8'h7F, 8'h01, 1'b0, 1'b1, mk(8'h7E, 1'b0, 1'b0));
    finish_op("ovf_7f_01", 1'b0, 8'h00, 8'h00, 1'b0, mk(8'h00, 1'b0, 1'b0));
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_busy();
    test_rst_mid();
    test_random();
`ifdef SUB_OVF_EN
    test_ovf();
`endif
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
